// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the serial receiver's deserializer stage.
// Counter-to-slot/offset helpers take log2(OVERSAMPLE) so one body serves every build.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  function automatic logic [15:0] slot_of(input logic [15:0] cnt, input int unsigned os_log2);
    return cnt >> os_log2;
  endfunction

  function automatic logic [15:0] offset_of(input logic [15:0] cnt, input int unsigned os_log2);
    return cnt & ((16'd1 << os_log2) - 16'd1);
  endfunction

endpackage

// File: rtl/majority3_sampler.sv
// Captures the line at the three centre ticks of a bit slot and votes on them.
// bit_strobe pulses the cycle after the last capture, while the counter is still in that slot.
module majority3_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int OFF_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             active,
  input  logic             in,
  input  logic [OFF_W-1:0] offset,
  output logic             bit_val,
  output logic             bit_strobe
);
  localparam int M = OVERSAMPLE / 2;

  logic [2:0] cap_q, cap_d;
  logic       strobe_q, strobe_d;
  logic       in_window;

  assign in_window = (offset == OFF_W'(M - 1)) || (offset == OFF_W'(M)) || (offset == OFF_W'(M + 1));

  always_comb begin
    cap_d    = cap_q;
    strobe_d = 1'b0;
    if (sample_en && active) begin
      if (in_window) cap_d = {cap_q[1:0], in};
      if (offset == OFF_W'(M + 1)) strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q    <= 3'b000;
      strobe_q <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      strobe_q <= strobe_d;
    end
  end

  assign bit_val    = (cap_q[0] & cap_q[1]) | (cap_q[0] & cap_q[2]) | (cap_q[1] & cap_q[2]);
  assign bit_strobe = strobe_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Frame deserializer: runs the oversampled bit counter after start-bit qualification,
// majority-samples data and stop bits, and presents the byte on a valid/ready output.
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 enable,
  input  logic                 in,
  output logic [CNT_W-1:0]     counter,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 frame_done,
  output rx_state_e            dbg_state
);
  localparam int OS_LOG2   = $clog2(OVERSAMPLE);
  localparam int FRAME_LEN = OVERSAMPLE * (DATA_BITS + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_ok_q, stop_ok_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done_q, frame_done_d;

  logic [15:0]          slot;
  logic [OS_LOG2-1:0]   offset;
  logic                 bit_val;
  logic                 bit_strobe;

  assign slot   = slot_of(16'(counter_q), OS_LOG2);
  assign offset = OS_LOG2'(offset_of(16'(counter_q), OS_LOG2));

  majority3_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .OFF_W      (OS_LOG2)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .active     (state_q == RUN),
    .in         (in),
    .offset     (offset),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe)
  );

  // Output handshake: a byte transfers on any cycle where out_valid and out_ready are both 1.
  // out_data/frame_err stay frozen while out_valid is 1 and the byte has not transferred; a
  // frame ending while the output is still full (and not being taken) is dropped and sets overrun.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    shift_d      = shift_q;
    stop_ok_d    = stop_ok_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (bit_strobe) begin
          if (slot >= 16'd1 && slot <= 16'(DATA_BITS)) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          else if (slot == 16'(DATA_BITS + 1)) stop_ok_d = bit_val;
        end
        if (sample_en) begin
          if (counter_q == LAST_CNT) begin
            counter_d    = '0;
            state_d      = RELEASE;
            frame_done_d = 1'b1;
            if (!out_valid_q || out_ready) begin
              out_data_d  = shift_q;
              frame_err_d = !stop_ok_q;
              out_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end
      end
      RELEASE: begin
        // Hold here until the detector drops enable, so a sticky enable cannot re-trigger.
        counter_d = '0;
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      shift_q      <= '0;
      stop_ok_q    <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      shift_q      <= shift_d;
      stop_ok_q    <= stop_ok_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign counter    = counter_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus randomized frames, checked against
// a transaction-level model of the output register (byte queue, valid, overrun, frame_done).
module tb_uart_rx_deserializer;
  import uart_rx_pkg::*;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int CW = 8;
  localparam int L  = OS * (DB + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic          enable;
  logic          in;
  logic          out_ready;
  logic [CW-1:0] counter;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          frame_err;
  logic          overrun;
  logic          frame_done;
  rx_state_e     dbg_state;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .enable     (enable),
    .in         (in),
    .counter    (counter),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: frames in flight as {frame_err, data}, plus the modelled output register.
  logic [DB:0]   exp_q[$];
  logic          m_valid, m_ferr, m_ovr, m_fd, commit_pending;
  logic [DB-1:0] m_data;
  logic          line[L];
  bit            ab;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_fd = 1'b0;
    m_data = '0; commit_pending = 1'b0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    if (m_valid) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
    end
  endtask

  // One clock: update the model with this cycle's inputs, advance, then compare.
  task automatic tick();
    logic [DB:0] e;
    if (commit_pending) begin
      e = exp_q.pop_front();
      if (!m_valid || out_ready) begin
        m_valid = 1'b1; m_data = e[DB-1:0]; m_ferr = e[DB];
      end else begin
        m_ovr = 1'b1;
      end
      m_fd = 1'b1;
      commit_pending = 1'b0;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      m_fd = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop, input int period,
                            input int glitch_at, input bit rand_glitch, input bit rand_ready,
                            input bit drop_en, input int abort_at, output bit aborted);
    aborted = 1'b0;
    for (int t = 0; t < L; t++) begin
      int k;
      k = t / OS;
      line[t] = (k == 0) ? 1'b0 : (k == DB + 1) ? stop : data[k-1];
    end
    // One flipped tick per slot can never outvote the two other centre captures.
    if (rand_glitch)
      for (int k = 0; k < DB + 2; k++)
        if ($urandom_range(1, 0) == 1) begin
          int p;
          p = k * OS + int'($urandom_range(OS - 1, 0));
          line[p] = ~line[p];
        end
    if (glitch_at >= 0) line[glitch_at] = ~line[glitch_at];
    exp_q.push_back({~stop, data});

    enable = 1'b0; in = 1'b1; sample_en = 1'b0;
    tick();
    enable = 1'b1; in = 1'b0;
    tick();
    for (int t = 0; t < L; t++) begin
      for (int g = 1; g < period; g++) begin
        sample_en = 1'b0;
        if (rand_ready) out_ready = 1'($urandom_range(1, 0));
        tick();
      end
      sample_en = 1'b1;
      in = line[t];
      if (rand_ready) out_ready = 1'($urandom_range(1, 0));
      if (drop_en && t == L / 2) enable = 1'b0;
      if (t == 0 || t == 70 || t == L - 1) check("counter", 32'(counter), 32'(t));
      if (t == 70) check("state_run", 32'(dbg_state), 32'(RUN));
      if (t == abort_at) begin
        #1 rst = 1'b0;
        #1;
        model_clear();
        exp_q.delete();
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        enable = 1'b0; sample_en = 1'b0; in = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        aborted = 1'b1;
        return;
      end
      if (t == L - 1) commit_pending = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    in = 1'b1;
    check("end_counter", 32'(counter), 32'd0);
    check("end_state", 32'(dbg_state), 32'(RELEASE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; sample_en = 1'b0; enable = 1'b0; in = 1'b1; out_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_counter", 32'(counter), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check_outputs();
    rst = 1'b1;
    tick();

    // 0xA5, good stop, consumer always ready: valid for exactly one cycle.
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1, -1, 1'b0, 1'b0, 1'b0, -1, ab);
    check("a5_data", 32'(out_data), 32'hA5);
    check("a5_done", 32'(frame_done), 32'd1);
    tick();
    check("a5_valid_drop", 32'(out_valid), 32'd0);

    // 0x3C with a bad stop bit, held until consumed.
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1, -1, 1'b0, 1'b0, 1'b0, -1, ab);
    check("3c_ferr", 32'(frame_err), 32'd1);
    repeat (3) tick();
    check("3c_held", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    tick();

    // 0x81 with a glitch on the centre sample of bit 0.
    send_frame(8'h81, 1'b1, 1, OS + OS / 2, 1'b0, 1'b0, 1'b0, -1, ab);
    check("81_data", 32'(out_data), 32'h81);
    tick();

    // Two frames into a stalled consumer: second byte dropped.
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1, -1, 1'b0, 1'b0, 1'b0, -1, ab);
    send_frame(8'h22, 1'b1, 1, -1, 1'b0, 1'b0, 1'b0, -1, ab);
    check("ovr_data", 32'(out_data), 32'h11);
    check("ovr_flag", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("ovr_valid_after_accept", 32'(out_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Slow sample_en, reset mid-frame at counter 70, then a clean frame.
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 4, -1, 1'b0, 1'b0, 1'b0, 70, ab);
    check("abort_taken", 32'(ab), 32'd1);
    send_frame(8'h5A, 1'b1, 4, -1, 1'b0, 1'b0, 1'b0, -1, ab);
    check("5a_data", 32'(out_data), 32'h5A);
    check("5a_done", 32'(frame_done), 32'd1);

    // Sticky enable: stays in RELEASE with the counter parked.
    sample_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in = 1'($urandom_range(1, 0));
      tick();
    end
    check("release_counter", 32'(counter), 32'd0);
    check("release_state", 32'(dbg_state), 32'(RELEASE));
    sample_en = 1'b0; in = 1'b1; enable = 1'b0;
    tick();
    check("release_to_idle", 32'(dbg_state), 32'(IDLE));
    send_frame(8'hC3, 1'b1, 1, -1, 1'b0, 1'b0, 1'b0, -1, ab);
    check("c3_data", 32'(out_data), 32'hC3);

    // Randomized frames: data, stop bit, strobe rate, glitches, consumer stalls, early enable drop.
    for (int n = 0; n < 10; n++) begin
      send_frame(8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(3, 1)),
                 -1, 1'b1, 1'b1, 1'($urandom_range(1, 0)), -1, ab);
      repeat (int'($urandom_range(4, 0))) begin
        out_ready = 1'($urandom_range(1, 0));
        tick();
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
